// File: rtl/source.sv
// Register-memory execution unit: 16 x 8-bit memory, one 16-bit instruction per clock.
// Each valid instruction reads two bytes, applies an ALU op and writes the result to a third.
module source (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [15:0]  instruction,
    output logic [127:0] memory,
    output logic [7:0]   r1,
    output logic [7:0]   r2,
    output logic [7:0]   r3
);

    logic [7:0] mem_q [16];
    logic [7:0] r1_q, r2_q, r3_q;

    logic [3:0] opcode;
    logic [3:0] addr_a, addr_b, addr_d;
    logic [7:0] op_a, op_b;
    logic [7:0] result;
    logic       valid;

    assign opcode = instruction[15:12];
    assign addr_a = instruction[11:8];
    assign addr_b = instruction[7:4];
    assign addr_d = instruction[3:0];

    // Operands come from pre-edge memory, so dest/source overlap reads the old value.
    assign op_a  = mem_q[addr_a];
    assign op_b  = mem_q[addr_b];
    assign valid = opcode[3];

    always_comb begin
        result = 8'h00;
        unique case (opcode[2:0])
            3'b000: result = op_a & op_b;
            3'b001: result = op_a | op_b;
            3'b010: result = op_a ^ op_b;
            3'b011: result = op_a + op_b;
            3'b100: result = op_a - op_b;
            3'b101: result = op_a * op_b;  // low byte of the product
            3'b110: result = ~op_a;
            3'b111: result = op_a;
            default: result = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) begin
                mem_q[i] <= 8'(i);
            end
            r1_q <= 8'h00;
            r2_q <= 8'h00;
            r3_q <= 8'h00;
        end else if (valid) begin
            mem_q[addr_d] <= result;
            r1_q          <= op_a;
            r2_q          <= op_b;
            r3_q          <= result;
        end
    end

    for (genvar g = 0; g < 16; g++) begin : g_mem_view
        assign memory[8*g +: 8] = mem_q[g];
    end

    assign r1 = r1_q;
    assign r2 = r2_q;
    assign r3 = r3_q;

endmodule

// File: tb/tb_source.sv
// Directed self-checking bench for the source execution unit.
// Expected memory images come from a hand-maintained byte array updated per test.
module tb_source;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [15:0]  instruction;
    logic [127:0] memory;
    logic [7:0]   r1, r2, r3;

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_mem [16];

    source dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instruction (instruction),
        .memory      (memory),
        .r1          (r1),
        .r2          (r2),
        .r3          (r3)
    );

    always #5 clk = ~clk;

    function automatic logic [127:0] image();
        logic [127:0] v;
        for (int i = 0; i < 16; i++) v[8*i +: 8] = exp_mem[i];
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) exp_mem[i] = 8'(i);
    endtask

    // Present an instruction for one rising edge, then settle past it.
    task automatic apply(input logic [15:0] ins);
        instruction = ins;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        apply(16'h0000);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_reset();
        apply(16'hBD21);  // valid op during reset must be ignored
        rst_n = 1'b1;
        checks++;
        if (memory !== image()) begin
            errors++;
            $display("FAIL reset_mem got %h want %h", memory, image());
        end
        checks++;
        if ({r1, r2, r3} !== 24'h000000) begin
            errors++;
            $display("FAIL reset_regs got %h want %h", {r1, r2, r3}, 24'h000000);
        end
    endtask

    task automatic test_add();
        apply(16'hBD21);
        exp_mem[1] = 8'h0F;
        checks++;
        if ({r1, r2, r3} !== 24'h0D020F) begin
            errors++;
            $display("FAIL add_regs got %h want %h", {r1, r2, r3}, 24'h0D020F);
        end
        checks++;
        if (memory !== image()) begin
            errors++;
            $display("FAIL add_mem got %h want %h", memory, image());
        end
    endtask

    task automatic test_sub();
        apply(16'hCE25);
        exp_mem[5] = 8'h0C;
        checks++;
        if ({r1, r2, r3} !== 24'h0E020C) begin
            errors++;
            $display("FAIL sub_regs got %h want %h", {r1, r2, r3}, 24'h0E020C);
        end
        checks++;
        if (memory !== image()) begin
            errors++;
            $display("FAIL sub_mem got %h want %h", memory, image());
        end
    endtask

    // Reads mem[5], written by the previous instruction.
    task automatic test_mul_dep();
        apply(16'hDF5B);
        exp_mem[11] = 8'hB4;
        checks++;
        if ({r1, r2, r3} !== 24'h0F0CB4) begin
            errors++;
            $display("FAIL mul_dep_regs got %h want %h", {r1, r2, r3}, 24'h0F0CB4);
        end
        checks++;
        if (memory !== image()) begin
            errors++;
            $display("FAIL mul_dep_mem got %h want %h", memory, image());
        end
    endtask

    task automatic test_and();
        apply(16'h867A);
        exp_mem[10] = 8'h06;
        checks++;
        if ({r1, r2, r3} !== 24'h060706) begin
            errors++;
            $display("FAIL and_regs got %h want %h", {r1, r2, r3}, 24'h060706);
        end
        checks++;
        if (memory !== image()) begin
            errors++;
            $display("FAIL and_mem got %h want %h", memory, image());
        end
    endtask

    // OR, XOR, NOT, PASS and a dest==srcA==srcB ADD, all from a fresh reset image.
    task automatic test_logic_ops();
        logic [15:0] ins  [5] = '{16'h9351, 16'hA362, 16'hE904, 16'hF708, 16'hBAAA};
        logic [23:0] regs [5] = '{24'h030507, 24'h030605, 24'h0900F6, 24'h070007, 24'h0A0A14};
        logic [3:0]  dst  [5] = '{4'd1, 4'd2, 4'd4, 4'd8, 4'd10};
        do_reset();
        for (int k = 0; k < 5; k++) begin
            apply(ins[k]);
            exp_mem[dst[k]] = regs[k][7:0];
            checks++;
            if ({r1, r2, r3} !== regs[k]) begin
                errors++;
                $display("FAIL ops_regs[%0d] got %h want %h", k, {r1, r2, r3}, regs[k]);
            end
            checks++;
            if (memory !== image()) begin
                errors++;
                $display("FAIL ops_mem[%0d] got %h want %h", k, memory, image());
            end
        end
    endtask

    task automatic test_wrap();
        do_reset();
        apply(16'hC120);
        exp_mem[0] = 8'hFF;
        checks++;
        if ({r1, r2, r3} !== 24'h0102FF) begin
            errors++;
            $display("FAIL sub_wrap_regs got %h want %h", {r1, r2, r3}, 24'h0102FF);
        end
        checks++;
        if (memory !== image()) begin
            errors++;
            $display("FAIL sub_wrap_mem got %h want %h", memory, image());
        end
        do_reset();
        apply(16'hDFFF);
        exp_mem[15] = 8'hE1;
        checks++;
        if ({r1, r2, r3} !== 24'h0F0FE1) begin
            errors++;
            $display("FAIL mul_wrap_regs got %h want %h", {r1, r2, r3}, 24'h0F0FE1);
        end
        checks++;
        if (memory !== image()) begin
            errors++;
            $display("FAIL mul_wrap_mem got %h want %h", memory, image());
        end
    endtask

    // State left by test_wrap: mem[15]=E1, regs 0F/0F/E1.
    task automatic test_nop();
        logic [15:0] nops [2] = '{16'h0123, 16'h7FFF};
        for (int k = 0; k < 2; k++) begin
            apply(nops[k]);
            checks++;
            if ({r1, r2, r3} !== 24'h0F0FE1) begin
                errors++;
                $display("FAIL nop_regs[%0d] got %h want %h", k, {r1, r2, r3}, 24'h0F0FE1);
            end
            checks++;
            if (memory !== image()) begin
                errors++;
                $display("FAIL nop_mem[%0d] got %h want %h", k, memory, image());
            end
        end
    endtask

    task automatic test_mid_reset();
        apply(16'hB120);
        exp_mem[0] = 8'h03;
        checks++;
        if (memory !== image()) begin
            errors++;
            $display("FAIL pre_reset_mem got %h want %h", memory, image());
        end
        rst_n = 1'b0;
        apply(16'hBD21);
        rst_n = 1'b1;
        model_reset();
        checks++;
        if (memory !== image()) begin
            errors++;
            $display("FAIL mid_reset_mem got %h want %h", memory, image());
        end
        checks++;
        if ({r1, r2, r3} !== 24'h000000) begin
            errors++;
            $display("FAIL mid_reset_regs got %h want %h", {r1, r2, r3}, 24'h000000);
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        instruction = 16'h0000;
        test_reset();
        test_add();
        test_sub();
        test_mul_dep();
        test_and();
        test_logic_ops();
        test_wrap();
        test_nop();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
